instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/isa_pkg.sv | 93 +++++++++
 rtl/enc_fifo.sv | 44 ++++
 rtl/instr_encoder.sv | 77 +++++++
 tb/tb_instr_encoder.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// Shared ISA definitions: request kinds, opcode/funct fields, ALU control codes
// and the single-word encode function used by the instruction encoder.
package isa_pkg;

  localparam int unsigned WORD_W = 32;

  typedef enum logic [2:0] {
    K_RTYPE = 3'd0,
    K_LW    = 3'd1,
    K_SW    = 3'd2,
    K_BEQ   = 3'd3,
    K_ADDI  = 3'd4,
    K_J     = 3'd5
  } kind_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  typedef struct packed {
    logic              legal;
    logic [WORD_W-1:0] word;
  } enc_t;

  // Builds the machine word; reserved kinds and unmapped ALU codes come back illegal.
  function automatic enc_t encode(input logic [2:0]  kind,
                                  input logic [4:0]  rs,
                                  input logic [4:0]  rt,
                                  input logic [4:0]  rd,
                                  input logic [4:0]  shamt,
                                  input logic [3:0]  alucontrol,
                                  input logic [15:0] imm,
                                  input logic [25:0] target);
    enc_t       res;
    logic [5:0] funct;
    logic       fn_ok;
    res   = '0;
    funct = '0;
    fn_ok = 1'b1;
    case (alucontrol)
      ALU_ADD: funct = FN_ADD;
      ALU_SUB: funct = FN_SUB;
      ALU_AND: funct = FN_AND;
      ALU_OR:  funct = FN_OR;
      ALU_SLT: funct = FN_SLT;
      default: fn_ok = 1'b0;
    endcase
    case (kind)
      K_RTYPE: begin
        res.legal = fn_ok;
        res.word  = {OP_RTYPE, rs, rt, rd, shamt, funct};
      end
      K_LW: begin
        res.legal = 1'b1;
        res.word  = {OP_LW, rs, rt, imm};
      end
      K_SW: begin
        res.legal = 1'b1;
        res.word  = {OP_SW, rs, rt, imm};
      end
      K_BEQ: begin
        res.legal = 1'b1;
        res.word  = {OP_BEQ, rs, rt, imm};
      end
      K_ADDI: begin
        res.legal = 1'b1;
        res.word  = {OP_ADDI, rs, rt, imm};
      end
      K_J: begin
        res.legal = 1'b1;
        res.word  = {OP_J, target};
      end
      default: res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/enc_fifo.sv
// Synchronous FIFO holding encoded words; pointers wrap naturally at DEPTH (power of 2).
module enc_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is deliberately left unreset; count gates its visibility.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/instr_encoder.sv
// Encodes instruction requests into 32-bit words and queues them in an output FIFO,
// flagging illegal requests on a sticky error bit.
module instr_encoder
  import isa_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  kind,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [3:0]  alucontrol,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] out_word,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        err,
  input  logic        clr_err,
  output logic [15:0] enc_count
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  enc_t          enc_c;
  logic [CW-1:0] count;
  logic          accept;
  logic          push;
  logic          pop;

  assign enc_c  = encode(kind, rs, rt, rd, shamt, alucontrol, imm, target);

  // Handshake decodes only registered occupancy, never out_ready.
  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != CW'(0));
  assign accept    = in_valid & in_ready;
  assign push      = accept & enc_c.legal;
  assign pop       = out_valid & out_ready;

  enc_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .din     (enc_c.word),
    .pop     (pop),
    .dout    (out_word),
    .count   (count)
  );

  // Setting on an illegal accept wins over a same-cycle clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err <= 1'b0;
    end else if (accept && !enc_c.legal) begin
      err <= 1'b1;
    end else if (clr_err) begin
      err <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enc_count <= '0;
    end else if (push) begin
      enc_count <= enc_count + 16'(1);
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: expected words queued at accept, checked on output transfer.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  kind = '0;
  logic [4:0]  rs = '0, rt = '0, rd = '0, shamt = '0;
  logic [3:0]  alucontrol = '0;
  logic [15:0] imm = '0;
  logic [25:0] target = '0;
  logic [31:0] out_word;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        err;
  logic        clr_err = 1'b0;
  logic [15:0] enc_count;

  logic [31:0] sb [$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_popped = 0;
  logic [15:0] exp_cnt  = '0;

  instr_encoder #(.DEPTH(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .kind       (kind),
    .rs         (rs),
    .rt         (rt),
    .rd         (rd),
    .shamt      (shamt),
    .alucontrol (alucontrol),
    .imm        (imm),
    .target     (target),
    .out_word   (out_word),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .err        (err),
    .clr_err    (clr_err),
    .enc_count  (enc_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] model(input logic [2:0] k, input logic [4:0] s, input logic [4:0] t,
                                        input logic [4:0] d, input logic [4:0] sh, input logic [3:0] a,
                                        input logic [15:0] im, input logic [25:0] tg, output logic ok);
    logic [5:0] fn;
    logic       fok;
    fok = 1'b1;
    fn  = 6'h00;
    case (a)
      4'b0010: fn = 6'h20;
      4'b0110: fn = 6'h22;
      4'b0000: fn = 6'h24;
      4'b0001: fn = 6'h25;
      4'b0111: fn = 6'h2a;
      default: fok = 1'b0;
    endcase
    ok = 1'b1;
    case (k)
      3'd0: begin ok = fok; return {6'h00, s, t, d, sh, fn}; end
      3'd1: return {6'h23, s, t, im};
      3'd2: return {6'h2b, s, t, im};
      3'd3: return {6'h04, s, t, im};
      3'd4: return {6'h08, s, t, im};
      3'd5: return {6'h02, tg};
      default: begin ok = 1'b0; return 32'h0; end
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one request until accepted (bounded); returns at posedge+1 after the accepting edge.
  task automatic send(input logic [2:0] k, input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                      input logic [4:0] sh, input logic [3:0] a, input logic [15:0] im, input logic [25:0] tg);
    logic [31:0] w;
    logic        ok;
    int          n;
    kind = k; rs = s; rt = t; rd = d; shamt = sh; alucontrol = a; imm = im; target = tg;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      check("accept_timeout", {31'b0, in_ready}, 32'd1);
    end else begin
      w = model(k, s, t, d, sh, a, im, tg, ok);
      if (ok) begin
        sb.push_back(w);
        exp_cnt = exp_cnt + 16'd1;
      end
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    out_ready = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      n++;
      @(negedge clk);
    end
    check("drain", 32'(sb.size()), 32'd0);
    step();
  endtask

  // Output monitor: every transfer must match the oldest expected word.
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      n_popped++;
      if (sb.size() == 0) check("extra_out", {31'b0, out_valid}, 32'd0);
      else check("out_word", out_word, sb.pop_front());
    end
  end

  initial begin
    logic [3:0] legal_alu [5];
    int         base;
    legal_alu[0] = 4'b0010; legal_alu[1] = 4'b0110; legal_alu[2] = 4'b0000;
    legal_alu[3] = 4'b0001; legal_alu[4] = 4'b0111;

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_err", {31'b0, err}, 32'd0);
    check("rst_enc_count", {16'b0, enc_count}, 32'd0);
    reset_n = 1'b1;
    step();

    // RTYPE add, visible one cycle after accept
    out_ready = 1'b1;
    send(3'd0, 5'd1, 5'd2, 5'd3, 5'd0, 4'b0010, 16'h0, 26'h0);
    @(negedge clk);
    check("rtype_valid", {31'b0, out_valid}, 32'd1);
    check("rtype_word", out_word, 32'h00221820);
    check("rtype_cnt", {16'b0, enc_count}, 32'd1);
    step();

    // LW then J, in order
    send(3'd1, 5'd29, 5'd8, 5'd0, 5'd0, 4'b0000, 16'h0004, 26'h0);
    @(negedge clk);
    check("lw_word", out_word, 32'h8FA80004);
    step();
    send(3'd5, 5'd0, 5'd0, 5'd0, 5'd0, 4'b0000, 16'h0, 26'h0000010);
    @(negedge clk);
    check("j_word", out_word, 32'h08000010);
    step();
    drain();

    // Backpressure: four fill the FIFO, fifth waits for one pop
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(3'd4, 5'(i), 5'(i + 1), 5'd0, 5'd0, 4'b0000, 16'(i * 3), 26'h0);
    @(negedge clk);
    check("full_in_ready", {31'b0, in_ready}, 32'd0);
    check("full_valid", {31'b0, out_valid}, 32'd1);
    step();
    kind = 3'd2; rs = 5'd7; rt = 5'd9; imm = 16'hBEEF; in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("full_hold", {31'b0, in_ready}, 32'd0);
    step();
    out_ready = 1'b0;
    @(negedge clk);
    check("after_pop_ready", {31'b0, in_ready}, 32'd1);
    sb.push_back(32'hACE9BEEF);
    exp_cnt = exp_cnt + 16'd1;
    step();
    in_valid = 1'b0;
    drain();
    check("bp_cnt", {16'b0, enc_count}, {16'b0, exp_cnt});

    // Illegal ALU code: error set, nothing queued, count unchanged
    send(3'd0, 5'd1, 5'd1, 5'd1, 5'd0, 4'b0101, 16'h0, 26'h0);
    @(negedge clk);
    check("ill_err", {31'b0, err}, 32'd1);
    check("ill_valid", {31'b0, out_valid}, 32'd0);
    check("ill_cnt", {16'b0, enc_count}, {16'b0, exp_cnt});
    step();
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    @(negedge clk);
    check("clr_err", {31'b0, err}, 32'd0);
    step();
    // Reserved kind together with clr_err: set wins
    clr_err = 1'b1;
    send(3'd7, 5'd0, 5'd0, 5'd0, 5'd0, 4'b0010, 16'h0, 26'h0);
    clr_err = 1'b0;
    @(negedge clk);
    check("set_priority", {31'b0, err}, 32'd1);
    check("rsv_valid", {31'b0, out_valid}, 32'd0);
    step();
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;

    // Streaming with pointer wrap over 12 words
    out_ready = 1'b1;
    base = n_popped;
    for (int i = 0; i < 12; i++) begin
      send(3'($urandom_range(0, 5)), 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
           legal_alu[$urandom_range(0, 4)], 16'($urandom), 26'($urandom));
      check("stream_ready", {31'b0, in_ready}, 32'd1);
    end
    drain();
    check("stream_words", 32'(n_popped - base), 32'd12);
    check("stream_cnt", {16'b0, enc_count}, {16'b0, exp_cnt});

    // Reset mid-operation with three queued
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(3'd3, 5'(i), 5'(i), 5'd0, 5'd0, 4'b0000, 16'(i), 26'h0);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'b0, out_valid}, 32'd0);
    check("mid_rst_cnt", {16'b0, enc_count}, 32'd0);
    check("mid_rst_ready", {31'b0, in_ready}, 32'd1);
    sb.delete();
    exp_cnt = '0;
    step();
    reset_n = 1'b1;
    step();
    out_ready = 1'b1;
    send(3'd0, 5'd4, 5'd5, 5'd6, 5'd0, 4'b0110, 16'h0, 26'h0);
    @(negedge clk);
    check("post_rst_word", out_word, 32'h00853022);
    check("post_rst_cnt", {16'b0, enc_count}, 32'd1);
    step();
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
